// File: rtl/abro_pkg.sv
// Shared definitions for the ABRO machine and its input conditioner:
// state encodings and default timing constants.
package abro_pkg;

    // ABRO machine state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEEN1 = 2'b01,
        SEEN2 = 2'b10,
        OUT   = 2'b11
    } abro_state_e;

    // Debounce channel state: either settled on the held level, or
    // counting consecutive cycles of disagreement.
    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } chan_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage : abro_pkg

// File: rtl/abro_debounce_channel.sv
// One conditioning channel: multi-flop synchroniser, debounce counter FSM
// and a registered rising-edge pulse on the accepted level.
module abro_debounce_channel
    import abro_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic sync_o,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Synchroniser shift chain; the raw line enters at bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce decision: accept a new level only after it has disagreed
    // with the held level for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single differing sample is already enough.
                        level_d = s;
                        rise_d  = s;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHECK: begin
                if (s == level_q) begin
                    // Glitch: input went back before the window completed.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = s;
                    rise_d  = s;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, counter, held level and rise pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign sync_o  = s;
    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule : abro_debounce_channel

// File: rtl/abro_input_conditioner.sv
// Front-end for the ABRO machine: two independent debounce channels for the
// raw A and B lines, plus a flag that is high when neither has a change pending.
module abro_input_conditioner
    import abro_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic A_raw,
    input  logic B_raw,
    output logic A,
    output logic B,
    output logic A_rise,
    output logic B_rise,
    output logic settled
);

    logic sync_a, sync_b;
    logic level_a, level_b;

    abro_debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (A_raw),
        .sync_o (sync_a),
        .level_o(level_a),
        .rise_o (A_rise)
    );

    abro_debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (B_raw),
        .sync_o (sync_b),
        .level_o(level_b),
        .rise_o (B_rise)
    );

    assign A = level_a;
    assign B = level_b;

    // Settled purely from registered state, so raw lines never reach an output.
    assign settled = (sync_a == level_a) && (sync_b == level_b);

endmodule : abro_input_conditioner

// File: tb/tb_abro_input_conditioner.sv
// Self-checking bench for abro_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_abro_input_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic A, B, A_rise, B_rise, settled;

    int n_checks = 0;
    int n_fail   = 0;
    int a_rises  = 0;

    // Reference model: raw sample history, synchronised sample history,
    // held level, rise pulse.
    logic m_raw [2][SS];
    logic m_s   [2][DC];
    logic m_d   [2];
    logic m_rise[2];

    typedef struct {
        logic a, b;
        logic ea, eb, ear, ebr, es;
    } vec_t;
    vec_t tbl[22];

    abro_input_conditioner #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .A_raw  (a_raw),
        .B_raw  (b_raw),
        .A      (A),
        .B      (B),
        .A_rise (A_rise),
        .B_rise (B_rise),
        .settled(settled)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < SS; i++) m_raw[c][i] = 1'b0;
            for (int i = 0; i < DC; i++) m_s[c][i] = 1'b0;
            m_d[c]    = 1'b0;
            m_rise[c] = 1'b0;
        end
    endfunction

    // A level is accepted once the last DC synchronised samples all differ
    // from the held level; the synchronised sample is the raw value SS edges old.
    function automatic void model_edge();
        logic raw_now, sp, all_diff;
        if (!rst_n) begin
            model_clear();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            raw_now = (c == 0) ? a_raw : b_raw;
            sp = m_raw[c][SS-1];
            for (int i = DC - 1; i > 0; i--) m_s[c][i] = m_s[c][i-1];
            m_s[c][0] = sp;
            all_diff = 1'b1;
            for (int i = 0; i < DC; i++) if (m_s[c][i] == m_d[c]) all_diff = 1'b0;
            m_rise[c] = 1'b0;
            if (all_diff) begin
                m_rise[c] = sp;
                m_d[c]    = sp;
            end
            for (int i = SS - 1; i > 0; i--) m_raw[c][i] = m_raw[c][i-1];
            m_raw[c][0] = raw_now;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".A"},       A,       m_d[0]);
        chk({tag, ".B"},       B,       m_d[1]);
        chk({tag, ".A_rise"},  A_rise,  m_rise[0]);
        chk({tag, ".B_rise"},  B_rise,  m_rise[1]);
        chk({tag, ".settled"}, settled,
            (m_raw[0][SS-1] == m_d[0]) && (m_raw[1][SS-1] == m_d[1]));
    endtask

    // One clock: drive inputs, take the edge, update the model, compare.
    task automatic step(input logic a, input logic b, input string tag);
        a_raw = a;
        b_raw = b;
        @(posedge clk);
        model_edge();
        #1;
        if (A_rise) a_rises++;
        check_model(tag);
    endtask

    // Asynchronous reset asserted between edges, held for n edges.
    task automatic async_reset(input int n);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_model("rst_async");
        repeat (n) step(a_raw, b_raw, "rst_hold");
        #2;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic a, b, ea, eb, ear, ebr, es);
        vec_t v;
        v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.ear = ear; v.ebr = ebr; v.es = es;
        return v;
    endfunction

    initial begin
        logic ra, rb;
        // A rises; then A falls while B rises; then A rises again with B held.
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 1, 0, 1);
        tbl[6]  = mk(1, 0, 1, 0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 1, 0, 0, 0, 1);
        tbl[8]  = mk(0, 1, 1, 0, 0, 0, 1);
        for (int i = 9; i <= 12; i++) tbl[i] = mk(0, 1, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 1, 0, 1, 1);
        tbl[14] = mk(0, 1, 0, 1, 0, 0, 1);
        tbl[15] = mk(1, 1, 0, 1, 0, 0, 1);
        for (int i = 16; i <= 19; i++) tbl[i] = mk(1, 1, 0, 1, 0, 0, 0);
        tbl[20] = mk(1, 1, 1, 1, 1, 0, 1);
        tbl[21] = mk(1, 1, 1, 1, 0, 0, 1);

        model_clear();
        #2;
        async_reset(3);
        step(0, 0, "post_rst");
        $display("reset: A=%b B=%b settled=%b", A, B, settled);

        async_reset(1);
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].a, tbl[i].b, $sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d.A", i),       A,       tbl[i].ea);
            chk($sformatf("tbl%0d.B", i),       B,       tbl[i].eb);
            chk($sformatf("tbl%0d.A_rise", i),  A_rise,  tbl[i].ear);
            chk($sformatf("tbl%0d.B_rise", i),  B_rise,  tbl[i].ebr);
            chk($sformatf("tbl%0d.settled", i), settled, tbl[i].es);
            $display("vec %0d: a_raw=%b b_raw=%b -> A=%b B=%b Ar=%b Br=%b s=%b",
                     i, tbl[i].a, tbl[i].b, A, B, A_rise, B_rise, settled);
        end

        // Glitch of 3 cycles is discarded.
        async_reset(1);
        a_rises = 0;
        repeat (3) step(1, 0, "g3_hi");
        repeat (10) step(0, 0, "g3_lo");
        chk("glitch3.A", A, 1'b0);
        chk("glitch3.rise_seen", (a_rises != 0), 1'b0);
        $display("glitch3: A=%b rises=%0d", A, a_rises);

        // Pulse of exactly 4 cycles is accepted once.
        async_reset(1);
        a_rises = 0;
        for (int k = 1; k <= 16; k++) begin
            step((k <= 4), 0, "g4");
            if (k == 5) chk("pulse4.A_e5", A, 1'b0);
            if (k == 6) begin
                chk("pulse4.A_e6", A, 1'b1);
                chk("pulse4.rise_e6", A_rise, 1'b1);
            end
        end
        chk("pulse4.one_rise", (a_rises == 1), 1'b1);
        $display("pulse4: rises=%0d", a_rises);

        // Reset mid-count with raw held high restarts the full latency.
        async_reset(1);
        a_rises = 0;
        repeat (3) step(1, 0, "mid_pre");
        async_reset(2);
        chk("midrst.A_cleared", A, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, "mid_post");
            if (k == 5) chk("midrst.A_e5", A, 1'b0);
            if (k == 6) begin
                chk("midrst.A_e6", A, 1'b1);
                chk("midrst.rise_e6", A_rise, 1'b1);
            end
        end
        chk("midrst.one_rise", (a_rises == 1), 1'b1);
        $display("midreset: A=%b rises=%0d", A, a_rises);

        // Bounce while falling: 0,0,1,0,... restarts the count, A falls at edge 9.
        async_reset(1);
        repeat (8) step(1, 0, "bnc_pre");
        for (int k = 1; k <= 10; k++) begin
            step((k == 3), 0, "bnc");
            if (k == 8) chk("bounce.A_e8", A, 1'b1);
            if (k == 9) begin
                chk("bounce.A_e9", A, 1'b0);
                chk("bounce.rise_e9", A_rise, 1'b0);
            end
        end
        $display("bounce: A=%b", A);

        // Randomised run against the model, with occasional resets.
        async_reset(1);
        ra = 1'b0;
        rb = 1'b0;
        for (int blk = 0; blk < 30; blk++) begin
            a_rises = 0;
            for (int k = 0; k < 50; k++) begin
                if ($urandom_range(7) == 0) ra = ~ra;
                if ($urandom_range(7) == 0) rb = ~rb;
                if ($urandom_range(299) == 0) async_reset(1);
                step(ra, rb, "rand");
            end
            $display("random block %0d: A=%b B=%b A rises=%0d", blk, A, B, a_rises);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_abro_input_conditioner
